lane_ram_be_clr: RTL and testbench
==================================

Name: lane_ram_be_clr

Overview:
Single-clock simple-dual-port RAM for decoder line and neighbour buffers. Generalises the byte-enable RAM to N lanes of parametrised width, with full-width write data and per-lane enables. Adds a hardware clear sequencer that sweeps every entry to a constant after reset or on request, plus a registered read handshake. Used for intra-pred and MV neighbour storage, which must start each slice from a known state.

Parameters:
LANE_W, 8, bits per lane.
LANES, 3, lane count; word width = LANES*LANE_W.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
CLR_VAL, 0, lane value written by the clear sweep (LANE_W bits, replicated across all lanes).

Ports:
clk  in  1  clock; all logic rises on posedge.
rst_n  in  1  asynchronous active-low reset.
clr_start  in  1  single-cycle pulse; starts (or restarts) a clear sweep.
busy  out  1  high while the clear sweep runs; wr_en and rd_en are ignored while high.
wr_en  in  1  write request.
wr_addr  in  ADDR_W  write address.
wr_data  in  LANES*LANE_W  write data; lane i = bits [i*LANE_W +: LANE_W].
wr_be  in  LANES  per-lane write enable.
rd_en  in  1  read request.
rd_addr  in  ADDR_W  read address.
rd_data  out  LANES*LANE_W  registered read data.
rd_valid  out  1  high the cycle rd_data carries the result of an accepted read.

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_data=0, FSM=CLEAR, clr_cnt=0. The memory array itself is not reset.
- FSM states: IDLE and CLEAR.
  - CLEAR: each cycle writes CLR_VAL to all lanes of entry clr_cnt, then clr_cnt increments.
  - CLEAR, clr_cnt==DEPTH-1: final write, next state IDLE, busy falls on the same edge.
  - Result: after rst_n releases, busy stays high for exactly DEPTH clock edges.
- IDLE and clr_start: next state CLEAR, clr_cnt=0, busy=1 from the next edge.
- CLEAR and clr_start: clr_cnt restarts at 0 and the sweep takes a full DEPTH cycles again.
- rst_n asserted mid-sweep: immediate return to the reset values; the sweep restarts from 0 after release.
- Write (IDLE, wr_en=1): on the edge, for each lane i with wr_be[i]=1, mem[wr_addr] lane i takes wr_data lane i. Lanes with wr_be[i]=0 are untouched. wr_be=0 is a legal no-op.
- Read (IDLE, rd_en=1): latency 1.
  - rd_data = mem[rd_addr] on the next edge, rd_valid=1 for that one cycle.
  - Without rd_en (or while busy), rd_valid=0 and rd_data holds its previous value.
- rd_en or wr_en while busy: dropped silently. No rd_valid is produced and memory is not modified.
- Read and write in the same cycle to different addresses: both proceed independently.
- Same-cycle collision (same address): behaviour is set by the optional feature below.
- Width rules: clr_cnt is ADDR_W+1 bits internally; wrap is never used for termination, the compare against DEPTH-1 is explicit.

Optional Feature:
LANE_RAM_WR_FWD_EN
- Defined: on a same-address read/write collision, each lane with wr_be[i]=1 returns the new wr_data lane. The other lanes return the stored value.
- Undefined: collision is read-first, so all lanes return the pre-write contents. The write still completes.
- Either way, the write itself is unaffected.

Decomposition:
- Shared package lane_ram_pkg:
  - clr_state_t enum (IDLE, CLEAR).
  - Default LANE_W, LANES, ADDR_W constants.
  - Lane-slice helper function.
- One natural sub-module, lane_ram_clr_fsm: owns the state, clr_cnt and busy, and emits clr_we and clr_addr. The top module muxes these against the user write port.
- The storage array and read register stay in the top module.

Test Plan (LANES=3, LANE_W=8, ADDR_W=5, CLR_VAL=8'h00):
- Reset release: count cycles with busy=1 -> exactly 32. Then read addresses 0..31 -> every rd_data=24'h000000, with rd_valid one cycle after each rd_en.
- Write addr 5, data 24'hA1B2C3, be=3'b111; then addr 5, data 24'hFFFFFF, be=3'b010; read addr 5 -> 24'hA1FFC3.
- Same-cycle write addr 7 (data 24'h112233, be=3'b001) and read addr 7, old contents 24'h000000 -> 24'h000033 with LANE_RAM_WR_FWD_EN, 24'h000000 without. A follow-up read returns 24'h000033 in both builds.
- clr_start in IDLE after filling addr 0..31 with 24'h5A5A5A; assert wr_en and rd_en during the sweep -> busy high 32 cycles, rd_valid stays 0, no memory change. Afterwards all entries read 24'h000000.
- Pulse clr_start at sweep cycle 10, then rst_n low at cycle 20 of the restarted sweep -> busy is 1 throughout. After release, busy drops exactly 32 cycles later and all entries read zero.
- No rd_en for 5 cycles after a read returning 24'hA1FFC3 -> rd_valid=0 and rd_data holds 24'hA1FFC3.

Source files
------------

// File: rtl/lane_ram_pkg.sv
// Shared types and defaults for the lane-enable RAM with clear sequencer.
package lane_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int LANE_W_DEF = 8;
   localparam int LANES_DEF  = 3;
   localparam int ADDR_W_DEF = 5;

   // Bit offset of lane 'lane' inside a packed word of lane_w-bit lanes.
   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/lane_ram_clr_fsm.sv
// Clear sequencer: sweeps every RAM entry once after reset or on clr_start,
// holding busy high for exactly DEPTH cycles.
module lane_ram_clr_fsm
   import lane_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam int              DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

   clr_state_t      state_reg, state_next;
   logic [ADDR_W:0] clr_cnt_reg, clr_cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // A request always restarts the sweep from entry 0, even mid-sweep.
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (clr_start) begin
         state_next   = CLEAR;
         clr_cnt_next = '0;
      end else if (state_reg == CLEAR) begin
         if (clr_cnt_reg == LAST) begin
            state_next   = IDLE;
            clr_cnt_next = '0;
         end else begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
         end
      end
   end

   assign busy     = (state_reg == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = clr_cnt_reg[ADDR_W-1:0];

endmodule

// File: rtl/lane_ram_be_clr.sv
// Simple-dual-port RAM with per-lane write enables, a clear sweep and a
// registered read. Optional macro LANE_RAM_WR_FWD_EN forwards collision writes.
module lane_ram_be_clr
   import lane_ram_pkg::*;
#(
   parameter int              LANE_W  = LANE_W_DEF,
   parameter int              LANES   = LANES_DEF,
   parameter int              ADDR_W  = ADDR_W_DEF,
   parameter logic [LANE_W-1:0] CLR_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_start,
   output logic                    busy,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [LANES*LANE_W-1:0] wr_data,
   input  logic [LANES-1:0]        wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [LANES*LANE_W-1:0] rd_data,
   output logic                    rd_valid
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_wr;
   logic              user_rd;
   logic [ADDR_W-1:0] waddr;
   logic              rd_valid_reg;

   lane_ram_clr_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clr_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_start (clr_start),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // User traffic is dropped outright while the sweep owns the array.
   assign user_wr = wr_en & ~busy;
   assign user_rd = rd_en & ~busy;
   assign waddr   = clr_we ? clr_addr : wr_addr;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : gen_lane
         logic [LANE_W-1:0] mem [DEPTH];
         logic [LANE_W-1:0] wr_lane;
         logic [LANE_W-1:0] lane_wdata;
         logic              lane_we;
         logic [LANE_W-1:0] rd_lane_next;
         logic [LANE_W-1:0] rd_lane_reg;

         assign wr_lane    = wr_data[lane_lsb(gi, LANE_W) +: LANE_W];
         assign lane_we    = clr_we | (user_wr & wr_be[gi]);
         assign lane_wdata = clr_we ? CLR_VAL : wr_lane;

         always_ff @(posedge clk) begin
            if (lane_we) begin
               mem[waddr] <= lane_wdata;
            end
         end

`ifdef LANE_RAM_WR_FWD_EN
         assign rd_lane_next = (user_wr && wr_be[gi] && (wr_addr == rd_addr)) ? wr_lane
                                                                              : mem[rd_addr];
`else
         assign rd_lane_next = mem[rd_addr];
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_lane_reg <= '0;
            end else if (user_rd) begin
               rd_lane_reg <= rd_lane_next;
            end
         end

         assign rd_data[lane_lsb(gi, LANE_W) +: LANE_W] = rd_lane_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= user_rd;
      end
   end

   assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_lane_ram_be_clr.sv
// Directed self-checking bench for lane_ram_be_clr (LANES=3, LANE_W=8, ADDR_W=5).
module tb_lane_ram_be_clr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_start;
   logic        busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [23:0] wr_data;
   logic [2:0]  wr_be;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [23:0] rd_data;
   logic        rd_valid;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   lane_ram_be_clr #(
      .LANE_W  (8),
      .LANES   (3),
      .ADDR_W  (5),
      .CLR_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_start (clr_start),
      .busy      (busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [23:0] d, input logic [2:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
      $display("WR addr=%0d data=%h be=%b", a, d, be);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [23:0] exp);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check(tag, {8'd0, rd_data}, {8'd0, exp});
      $display("RD addr=%0d data=%h valid=%b", a, rd_data, rd_valid);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int bad;
      logic [23:0] exp_col;

      rst_n = 1'b0; clr_start = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = 1'b0; rd_addr = '0;
      tick(); tick();
      check("reset_busy", {31'd0, busy}, 32'd1);
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_rd_data", {8'd0, rd_data}, 32'd0);

      // Power-up sweep
      rst_n = 1'b1;
      count_busy(n);
      check("reset_sweep_len", n, 32'd32);
      for (int i = 0; i < 32; i++) rd_chk("init_zero", 5'(i), 24'h000000);

      // Lane-enable merge
      wr(5'd5, 24'hA1B2C3, 3'b111);
      wr(5'd5, 24'hFFFFFF, 3'b010);
      rd_chk("be_merge", 5'd5, 24'hA1FFC3);

      // Idle hold: rd_data keeps last value
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rd_valid !== 1'b0 || rd_data !== 24'hA1FFC3) bad++;
      end
      check("idle_hold_valid", {31'd0, rd_valid}, 32'd0);
      check("idle_hold_data", {8'd0, rd_data}, 32'h00A1FFC3);
      check("idle_hold_cycles", bad, 32'd0);

      // Read and write to different addresses in one cycle
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 24'h445566; wr_be = 3'b111;
      rd_en = 1'b1; rd_addr = 5'd5;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check("rw_diff_valid", {31'd0, rd_valid}, 32'd1);
      check("rw_diff_data", {8'd0, rd_data}, 32'h00A1FFC3);
      rd_chk("rw_diff_wr", 5'd9, 24'h445566);

      // Same-address collision
`ifdef LANE_RAM_WR_FWD_EN
      exp_col = 24'h000033;
`else
      exp_col = 24'h000000;
`endif
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 24'h112233; wr_be = 3'b001;
      rd_en = 1'b1; rd_addr = 5'd7;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      $display("COLLIDE addr=7 data=%h valid=%b", rd_data, rd_valid);
      check("collide_valid", {31'd0, rd_valid}, 32'd1);
      check("collide_data", {8'd0, rd_data}, {8'd0, exp_col});
      rd_chk("collide_after", 5'd7, 24'h000033);

      // Clear on request, with traffic ignored during the sweep
      for (int i = 0; i < 32; i++) wr(5'(i), 24'h5A5A5A, 3'b111);
      rd_chk("fill_5a", 5'd3, 24'h5A5A5A);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 24'hFFFFFF; wr_be = 3'b111;
      rd_en = 1'b1; rd_addr = 5'd3;
      n = 0; bad = 0;
      while (busy && n < 100) begin
         if (rd_valid !== 1'b0) bad++;
         n++;
         tick();
      end
      wr_en = 1'b0; rd_en = 1'b0;
      $display("CLEAR busy_cycles=%0d", n);
      check("clr_sweep_len", n, 32'd32);
      check("clr_no_rd_valid", bad, 32'd0);
      check("clr_end_rd_valid", {31'd0, rd_valid}, 32'd0);
      for (int i = 0; i < 32; i++) rd_chk("clr_zero", 5'(i), 24'h000000);

      // Restart mid-sweep, then reset mid-sweep
      wr(5'd0, 24'h5A5A5A, 3'b111);
      wr(5'd15, 24'h5A5A5A, 3'b111);
      wr(5'd31, 24'h5A5A5A, 3'b111);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy !== 1'b1) bad++;
         tick();
      end
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b1) bad++;
         tick();
      end
      check("restart_busy_held", bad, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd1);
      check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("midrst_rd_data", {8'd0, rd_data}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      count_busy(n);
      $display("RESET-SWEEP busy_cycles=%0d", n);
      check("midrst_sweep_len", n, 32'd32);
      for (int i = 0; i < 32; i++) rd_chk("midrst_zero", 5'(i), 24'h000000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
